// File: rtl/apb_master.sv
// apb_master: request/response command port to a two-slave APB bus.
// One transfer at a time, with an ACCESS-phase wait timeout that returns an error response.
`default_nettype none

module apb_master #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [8:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA1,
  input  logic [7:0] PRDATA2,
  input  logic       PREADY1,
  input  logic       PREADY2
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            psel1_q, psel1_d;
  logic            psel2_q, psel2_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [7:0]      paddr_q, paddr_d;
  logic [7:0]      pwdata_q, pwdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [7:0]      rsp_rdata_q, rsp_rdata_d;

  logic            w_ready;
  logic [7:0]      w_rdata;

  // Only the latched slave's handshake is looked at; the other is don't-care.
  assign w_ready = sel_q ? PREADY2 : PREADY1;
  assign w_rdata = sel_q ? PRDATA2 : PRDATA1;

  assign req_ready = (state_q == IDLE) && reset;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    psel1_d     = psel1_q;
    psel2_d     = psel2_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d   = SETUP;
          sel_d     = req_addr[8];
          cnt_d     = '0;
          psel1_d   = ~req_addr[8];
          psel2_d   = req_addr[8];
          penable_d = 1'b0;
          pwrite_d  = req_write;
          paddr_d   = req_addr[7:0];
          pwdata_d  = req_wdata;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        if (w_ready) begin
          state_d     = IDLE;
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? 8'h00 : w_rdata;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // This low cycle is the TIMEOUT-th in a row: give up.
          state_d     = IDLE;
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'h00;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        psel1_d   = 1'b0;
        psel2_d   = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      cnt_q       <= '0;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 8'h00;
      pwdata_q    <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      psel1_q     <= psel1_d;
      psel2_q     <= psel2_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// tb_apb_master: scoreboard bench for apb_master with two memory-backed APB slave models.
`default_nettype none

module tb_apb_master;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [8:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic [7:0] PRDATA1, PRDATA2;
  logic       PREADY1, PREADY2;

  apb_master #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY1(PREADY1), .PREADY2(PREADY2)
  );

  always #5 clk = ~clk;

  // Slave models: memories, wait-state count per slave, and a never-ready switch for slave 2.
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  int         acc1 = 0, acc2 = 0;
  int         wait1 = 0, wait2 = 0;
  bit         never2 = 1'b0;

  assign PREADY1 = (acc1 >= wait1);
  assign PREADY2 = !never2 && (acc2 >= wait2);
  assign PRDATA1 = mem1[PADDR];
  assign PRDATA2 = mem2[PADDR];

  always @(posedge clk) begin
    acc1 <= (PSEL1 && PENABLE) ? acc1 + 1 : 0;
    acc2 <= (PSEL2 && PENABLE) ? acc2 + 1 : 0;
    if (PSEL1 && PENABLE && PREADY1 && PWRITE) mem1[PADDR] <= PWDATA;
    if (PSEL2 && PENABLE && PREADY2 && PWRITE) mem2[PADDR] <= PWDATA;
  end

  typedef struct {
    bit         wr;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    bit         err;
    int         lat;
  } exp_t;

  exp_t expq[$];
  int   accq[$];
  int   acc_hist[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: bus-protocol checks and scoreboard comparison of responses.
  int         en_cnt = 0;
  logic [7:0] h_addr, h_wdata;
  logic       h_write;

  always @(negedge clk) begin
    exp_t e;
    int   acc;
    cyc++;
    if (req_valid && req_ready) begin
      accq.push_back(cyc);
      acc_hist.push_back(cyc);
    end
    if (PSEL1 || PSEL2) chk("one_psel", {31'd0, PSEL1 & PSEL2}, 0);
    if (PENABLE && !(PSEL1 || PSEL2)) chk("penable_without_psel", 1, 0);
    if ((PSEL1 || PSEL2) && !PENABLE) begin
      if (expq.size() == 0 || accq.size() == 0) chk("unexpected_setup", 1, 0);
      else begin
        e = expq[0];
        chk("setup_latency", cyc - accq[0], 1);
        chk("setup_psel1", {31'd0, PSEL1}, {31'd0, !e.addr[8]});
        chk("setup_psel2", {31'd0, PSEL2}, {31'd0, e.addr[8]});
        chk("setup_paddr", {24'd0, PADDR}, {24'd0, e.addr[7:0]});
        chk("setup_pwrite", {31'd0, PWRITE}, {31'd0, e.wr});
        if (e.wr) chk("setup_pwdata", {24'd0, PWDATA}, {24'd0, e.wdata});
      end
      h_addr  = PADDR;
      h_wdata = PWDATA;
      h_write = PWRITE;
      en_cnt  = 0;
    end
    if ((PSEL1 || PSEL2) && PENABLE) begin
      en_cnt++;
      chk("stable_paddr", {24'd0, PADDR}, {24'd0, h_addr});
      chk("stable_pwdata", {24'd0, PWDATA}, {24'd0, h_wdata});
      chk("stable_pwrite", {31'd0, PWRITE}, {31'd0, h_write});
    end
    if (rsp_valid) begin
      if (expq.size() == 0 || accq.size() == 0) chk("spurious_rsp", 1, 0);
      else begin
        e   = expq.pop_front();
        acc = accq.pop_front();
        chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("rsp_latency", cyc - acc, e.lat);
        chk("access_cycles", en_cnt, e.lat - 2);
        chk("rsp_req_ready", {31'd0, req_ready}, 1);
        chk("rsp_bus_idle", {29'd0, PSEL1, PSEL2, PENABLE}, 0);
      end
    end
  end

  task automatic issue(input bit wr, input logic [8:0] a, input logic [7:0] wd,
                       input logic [7:0] rd, input bit er, input int lat);
    exp_t e;
    int   n = 0;
    e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd; e.err = er; e.lat = lat;
    expq.push_back(e);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) chk("drain_timeout", expq.size(), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int base;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 8'h00;
      mem2[i] = 8'h00;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_bus", {11'd0, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA}, 0);
    chk("reset_rsp", {22'd0, rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("reset_req_ready", {31'd0, req_ready}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_req_ready", {31'd0, req_ready}, 1);
    @(posedge clk);
    #1;

    // Slave 1 write/read, then slave 2 decode
    issue(1'b1, 9'h003, 8'hA5, 8'h00, 1'b0, 3); drain();
    issue(1'b0, 9'h003, 8'h00, 8'hA5, 1'b0, 3); drain();
    issue(1'b1, 9'h105, 8'h3C, 8'h00, 1'b0, 3); drain();
    issue(1'b0, 9'h105, 8'h00, 8'h3C, 1'b0, 3); drain();

    // Three wait states on slave 1
    wait1 = 3;
    issue(1'b1, 9'h010, 8'h77, 8'h00, 1'b0, 6); drain();
    issue(1'b0, 9'h010, 8'h00, 8'h77, 1'b0, 6); drain();
    wait1 = 0;

    // Slave 2 never ready: error after TIMEOUT access cycles
    never2 = 1'b1;
    issue(1'b0, 9'h101, 8'h00, 8'h00, 1'b1, 18); drain();
    never2 = 1'b0;

    // Reset during ACCESS of a write
    wait1 = 20;
    issue(1'b1, 9'h020, 8'hEE, 8'h00, 1'b0, 3);
    n = 0;
    @(negedge clk);
    while (!PENABLE && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached_access", {31'd0, PENABLE}, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_bus", {11'd0, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA}, 0);
    chk("midreset_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("midreset_req_ready", {31'd0, req_ready}, 0);
    expq.delete();
    accq.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait1 = 0;
    issue(1'b0, 9'h020, 8'h00, 8'h00, 1'b0, 3); drain();
    issue(1'b0, 9'h003, 8'h00, 8'hA5, 1'b0, 3); drain();

    // Back-to-back requests with req_valid held
    base = acc_hist.size();
    issue(1'b1, 9'h030, 8'h11, 8'h00, 1'b0, 3);
    issue(1'b1, 9'h131, 8'h22, 8'h00, 1'b0, 3);
    issue(1'b0, 9'h030, 8'h00, 8'h11, 1'b0, 3);
    issue(1'b0, 9'h131, 8'h00, 8'h22, 1'b0, 3);
    drain();
    chk("b2b_accepts", acc_hist.size() - base, 4);
    if (acc_hist.size() - base == 4) begin
      for (int i = 1; i < 4; i++)
        chk("b2b_spacing", acc_hist[base + i] - acc_hist[base + i - 1], 3);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/apb_master.md
# apb_master

Bridge that converts a simple request/response command interface into APB transfers for the two slaves on the local peripheral bus. One transfer at a time: it latches a request, runs the APB SETUP and ACCESS phases, waits on the selected slave's PREADY, and returns read data or error on a one-cycle response strobe. Sits directly upstream of both slaves. It drives their PSEL, PENABLE, PWRITE, PADDR and PWDATA and consumes their PRDATA and PREADY.

## Interface
- TIMEOUT, 16: max ACCESS cycles with PREADY low before abort (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  master can accept request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  9  [8] slave select (0 → slave 1, 1 → slave 2), [7:0] → PADDR
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion strobe, no backpressure
- rsp_rdata  out  8  read data, valid with rsp_valid
- rsp_err  out  1  timeout abort, valid with rsp_valid
- PSEL1  out  1  select slave 1
- PSEL2  out  1  select slave 2
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  8  APB address
- PWDATA  out  8  APB write data
- PRDATA1, PRDATA2  in  8  slave read data
- PREADY1, PREADY2  in  1  slave ready

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered except req_ready, which is high exactly when state == IDLE and reset is high.
- IDLE: if req_valid && req_ready, latch write, addr, wdata and the select bit. Next state is SETUP.
- SETUP: drive PSEL of the selected slave = 1, PENABLE = 0, and the latched PADDR/PWRITE/PWDATA. Next state is ACCESS unconditionally.
- ACCESS: PSEL stays 1 and PENABLE = 1. The selected slave's PREADY (PREADY1 or PREADY2 per the latched select) is sampled each cycle; the unselected PREADY is ignored.
  - PREADY high: the transfer completes. Next cycle: IDLE, PSEL/PENABLE = 0, rsp_valid = 1, rsp_err = 0. rsp_rdata is the selected PRDATA captured on the completing edge for reads, and 0 for writes.
  - PREADY low: increment wait counter. When the counter would reach TIMEOUT (i.e. TIMEOUT consecutive low cycles), abort. Next cycle: IDLE, PSEL/PENABLE = 0, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
- Wait counter clears on every entry to SETUP; width is $clog2(TIMEOUT+1).
- Only one PSEL is ever high. PADDR, PWRITE and PWDATA are stable from SETUP through the last ACCESS cycle. They hold their last values in IDLE; PSEL = 0 there.
- rsp_valid is high for exactly one cycle per accepted request. The consumer must take it; there is no stall.

## Timing
- Reset (reset == 0 at a clk edge): state IDLE, PSEL1 = PSEL2 = PENABLE = PWRITE = 0, PADDR = PWDATA = 0, rsp_valid = rsp_err = 0, rsp_rdata = 0, wait counter = 0. req_ready is 0 while reset is low.
- Reset asserted in SETUP or ACCESS aborts the transfer silently: no rsp_valid, and the bus is idle on the next cycle.
- Latency with zero-wait slave: request accepted at edge T. SETUP in cycle T+1, ACCESS in cycle T+2, rsp_valid in cycle T+3. req_ready is high again in cycle T+3, so the minimum request period is 3 cycles.
- Each PREADY-low ACCESS cycle adds one cycle of latency.
- With a slave that never readies, the abort response appears TIMEOUT+2 cycles after accept.
- req_valid while not in IDLE is ignored. The requester holds the request until req_ready is high.

## Test plan
- Write/read slave 1: write addr 0x003, data 0xA5, then read addr 0x003. Required: PSEL1 high for cycles T+1..T+2, PENABLE only in T+2, rsp_valid at T+3 with rsp_err = 0; the read returns rsp_rdata = 0xA5. PSEL2 stays 0 throughout.
- Slave 2 decode: write addr 0x105, data 0x3C, then read 0x105. Required: only PSEL2 toggles, PADDR = 0x05, read returns 0x3C.
- Wait states: a PREADY1 model holds low for 3 ACCESS cycles. Required: PENABLE high 4 cycles, PADDR/PWDATA stable throughout, rsp_valid at T+6, rsp_err = 0.
- Timeout: TIMEOUT = 16, PREADY2 tied 0, read 0x101. Required: exactly 16 ACCESS cycles, then rsp_valid with rsp_err = 1 and rsp_rdata = 0. req_ready returns to 1 in the same cycle.
- Reset mid-transfer: assert reset low during the ACCESS cycle of a write. Required: next cycle all bus outputs 0 and no rsp_valid. After reset is released, a new read completes normally.
- Back-to-back: req_valid held high with 4 queued requests. Required: accepts spaced exactly 3 cycles apart, 4 rsp_valid pulses, and never more than one PSEL high.
